// File: rtl/multiexp_pnt_scl_src_pkg.sv
// Shared types for the multiexp point/scalar source: default point and scalar types,
// the pair layout carried on the stream, and the mode codes the core decodes from ctl[0].
package multiexp_pnt_scl_src_pkg;

    typedef logic [15:0] fp_t;
    typedef logic [7:0]  fe_t;

    typedef struct packed {
        fp_t pnt;
        fe_t scl;
    } pnt_scl_t;

    localparam logic MODE_NORMAL     = 1'b0;
    localparam logic MODE_SINGLE_ADD = 1'b1;

endpackage

// File: rtl/multiexp_pnt_scl_src_if.sv
// AXI-stream style bundle used for both the pair load path and the replay stream.
interface multiexp_pnt_scl_src_if
    import multiexp_pnt_scl_src_pkg::*;
#(
    parameter int DAT_BITS = $bits(pnt_scl_t),
    parameter int CTL_BITS = 1
);

    logic                val;
    logic                rdy;
    logic                sop;
    logic                eop;
    logic [DAT_BITS-1:0] dat;
    logic [CTL_BITS-1:0] ctl;

    modport master (output val, sop, eop, dat, ctl, input rdy);
    modport slave  (input val, sop, eop, dat, ctl, output rdy);

endinterface

// File: rtl/multiexp_pnt_scl_src_pnt_scl_ram.sv
// Simple dual-port pair storage: one write port, one read port with a registered output
// that holds its value when no read is issued.
module pnt_scl_ram
    import multiexp_pnt_scl_src_pkg::*;
#(
    parameter int WIDTH = $bits(pnt_scl_t),
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/multiexp_pnt_scl_src.sv
// Source side of the multiexp point/scalar stream: loads pairs into RAM while idle, then
// replays them as KEY_BITS passes of NUM_IN beats (or one single-add beat) through a 2-entry buffer.
module multiexp_pnt_scl_src
    import multiexp_pnt_scl_src_pkg::*;
#(
    parameter type FP_TYPE  = fp_t,
    parameter type FE_TYPE  = fe_t,
    parameter int  KEY_BITS = 3,
    parameter int  CTL_BITS = 1,
    parameter int  NUM_IN   = 4
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    multiexp_pnt_scl_src_if.slave  i_load_if,
    multiexp_pnt_scl_src_if.master o_pnt_scl_if,
    input  logic                   i_start,
    input  logic                   i_mode,
    output logic                   o_busy,
    output logic                   o_done
);

    localparam int DAT_W = $bits(FP_TYPE) + $bits(FE_TYPE);
    localparam int AW    = $clog2(NUM_IN);
    localparam int PW    = $clog2(KEY_BITS) + 1;

    localparam logic [AW-1:0] LAST_ADDR = AW'(NUM_IN - 1);
    localparam logic [PW-1:0] LAST_PASS = PW'(KEY_BITS - 1);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] STREAM = 2'd1;
    localparam logic [1:0] DRAIN  = 2'd2;

    logic [1:0]    state;
    logic [AW-1:0] wr_addr;
    logic [AW-1:0] rd_addr;
    logic [PW-1:0] pass_cnt;
    logic          mode;
    logic          busy;
    logic          load_rdy;
    logic          done;

    logic [DAT_W-1:0] ram_q;
    logic             ram_vld;
    logic             ram_sop;
    logic             ram_eop;

    logic [DAT_W-1:0] buf_dat [2];
    logic [1:0]       buf_sop;
    logic [1:0]       buf_eop;
    logic             buf_wp;
    logic             buf_rp;
    logic [1:0]       buf_cnt;

    logic             load_hs;
    logic             rd_en;
    logic             buf_empty;
    logic [1:0]       occ;
    logic             out_val;
    logic             out_hs;
    logic             push;
    logic             pop;
    logic             last_beat;
    logic [DAT_W-1:0] head_dat;
    logic             head_sop;
    logic             head_eop;

    // The RAM output register counts as the in-flight read; a beat leaves it each cycle,
    // either straight onto the stream or into the buffer, so reads are gated on occ alone.
    assign load_hs   = (state == IDLE) && load_rdy && i_load_if.val;
    assign buf_empty = (buf_cnt == 2'd0);
    assign occ       = buf_cnt + 2'(ram_vld);
    assign rd_en     = (state == STREAM) && (occ < 2'd2);
    assign out_val   = !buf_empty || ram_vld;
    assign out_hs    = out_val && o_pnt_scl_if.rdy;
    assign pop       = out_hs && !buf_empty;
    assign push      = ram_vld && !(out_hs && buf_empty);
    assign last_beat = (state == DRAIN) && out_hs && (occ == 2'd1);

    assign head_dat = buf_empty ? ram_q   : buf_dat[buf_rp];
    assign head_sop = buf_empty ? ram_sop : buf_sop[buf_rp];
    assign head_eop = buf_empty ? ram_eop : buf_eop[buf_rp];

    assign o_pnt_scl_if.val = out_val;
    assign o_pnt_scl_if.dat = out_val ? head_dat : '0;
    assign o_pnt_scl_if.sop = out_val && head_sop;
    assign o_pnt_scl_if.eop = out_val && head_eop;
    assign o_pnt_scl_if.ctl = out_val ? CTL_BITS'(mode) : '0;
    assign i_load_if.rdy    = load_rdy;
    assign o_busy           = busy;
    assign o_done           = done;

    pnt_scl_ram #(
        .WIDTH (DAT_W),
        .DEPTH (NUM_IN),
        .AW    (AW)
    ) u_ram (
        .clk   (i_clk),
        .we    (load_hs),
        .waddr (wr_addr),
        .wdata (i_load_if.dat),
        .re    (rd_en),
        .raddr (rd_addr),
        .rdata (ram_q)
    );

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state    <= IDLE;
            wr_addr  <= '0;
            rd_addr  <= '0;
            pass_cnt <= '0;
            mode     <= MODE_NORMAL;
            busy     <= 1'b0;
            load_rdy <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (load_hs) begin
                        wr_addr <= (i_load_if.eop || wr_addr == LAST_ADDR) ? '0 : wr_addr + AW'(1);
                    end
                    if (i_start) begin
                        mode     <= i_mode;
                        rd_addr  <= '0;
                        pass_cnt <= '0;
                        busy     <= 1'b1;
                        load_rdy <= 1'b0;
                        state    <= STREAM;
                    end else begin
                        load_rdy <= 1'b1;
                    end
                end
                STREAM: begin
                    if (rd_en) begin
                        if (mode == MODE_SINGLE_ADD) begin
                            state <= DRAIN;
                        end else if (rd_addr == LAST_ADDR) begin
                            rd_addr <= '0;
                            if (pass_cnt == LAST_PASS) begin
                                state <= DRAIN;
                            end else begin
                                pass_cnt <= pass_cnt + PW'(1);
                            end
                        end else begin
                            rd_addr <= rd_addr + AW'(1);
                        end
                    end
                end
                DRAIN: begin
                    // done is raised on the final handshake and the return to IDLE follows it
                    if (done) begin
                        busy     <= 1'b0;
                        load_rdy <= 1'b1;
                        state    <= IDLE;
                    end else if (last_beat) begin
                        done <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            ram_vld <= 1'b0;
            ram_sop <= 1'b0;
            ram_eop <= 1'b0;
        end else begin
            ram_vld <= rd_en;
            if (rd_en) begin
                ram_sop <= (rd_addr == '0);
                ram_eop <= (rd_addr == LAST_ADDR) || (mode == MODE_SINGLE_ADD);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            buf_cnt <= 2'd0;
            buf_wp  <= 1'b0;
            buf_rp  <= 1'b0;
            buf_sop <= 2'b00;
            buf_eop <= 2'b00;
        end else begin
            if (push) begin
                buf_sop[buf_wp] <= ram_sop;
                buf_eop[buf_wp] <= ram_eop;
                buf_wp          <= ~buf_wp;
            end
            if (pop) begin
                buf_rp <= ~buf_rp;
            end
            buf_cnt <= buf_cnt + 2'(push) - 2'(pop);
        end
    end

    always_ff @(posedge i_clk) begin
        if (push) begin
            buf_dat[buf_wp] <= ram_q;
        end
    end

endmodule

// File: tb/tb_multiexp_pnt_scl_src.sv
// Directed bench for multiexp_pnt_scl_src with NUM_IN=4, KEY_BITS=3: expected beat tables
// replayed against the stream, plus hand-written reset, wrap and backpressure sequences.
`timescale 1ns/1ps
module tb_multiexp_pnt_scl_src;
    import multiexp_pnt_scl_src_pkg::*;

    localparam int NUM_IN   = 4;
    localparam int KEY_BITS = 3;
    localparam int CTL_BITS = 2;
    localparam int DAT_W    = $bits(pnt_scl_t);

    typedef struct {
        logic [7:0] scl;
        logic       sop;
        logic       eop;
    } beat_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic mode  = 1'b0;
    logic busy;
    logic done;

    int    checks   = 0;
    int    failures = 0;
    beat_t exp_q[$];
    beat_t normal_tbl[12];

    multiexp_pnt_scl_src_if #(.DAT_BITS(DAT_W), .CTL_BITS(CTL_BITS)) load_if ();
    multiexp_pnt_scl_src_if #(.DAT_BITS(DAT_W), .CTL_BITS(CTL_BITS)) out_if ();

    multiexp_pnt_scl_src #(
        .FP_TYPE  (fp_t),
        .FE_TYPE  (fe_t),
        .KEY_BITS (KEY_BITS),
        .CTL_BITS (CTL_BITS),
        .NUM_IN   (NUM_IN)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_load_if    (load_if),
        .o_pnt_scl_if (out_if),
        .i_start      (start),
        .i_mode       (mode),
        .o_busy       (busy),
        .o_done       (done)
    );

    always #5 clk = ~clk;

    function automatic pnt_scl_t pair(input logic [7:0] k);
        pnt_scl_t p;
        p.pnt = 16'hA000 | {8'h00, k};
        p.scl = k;
        return p;
    endfunction

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic apply_stimulus(input logic [7:0] k, input logic last);
        int waited = 0;
        @(negedge clk);
        while (load_if.rdy !== 1'b1 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        check_output("load_rdy", 64'(load_if.rdy), 64'(1));
        load_if.val = 1'b1;
        load_if.dat = pair(k);
        load_if.eop = last;
        @(negedge clk);
        load_if.val = 1'b0;
        load_if.eop = 1'b0;
    endtask

    task automatic start_run(input logic m);
        @(negedge clk);
        start = 1'b1;
        mode  = m;
        @(negedge clk);
        start = 1'b0;
        mode  = 1'b0;
    endtask

    task automatic build_normal(input logic [31:0] vals);
        exp_q.delete();
        for (int p = 0; p < KEY_BITS; p++) begin
            for (int a = 0; a < NUM_IN; a++) begin
                exp_q.push_back('{vals[8*a +: 8], (a == 0), (a == NUM_IN - 1)});
            end
        end
    endtask

    // Walks the stream one cycle at a time from the cycle after start is taken, comparing each
    // handshaken beat with exp_q, and checks stall stability, done timing and load_rdy.
    task automatic check_stream(input string tag, input logic m, input int rdy_pct,
                                input bit poke, input int exp_busy);
        int            idx       = 0;
        int            cyc       = 0;
        int            done_cnt  = 0;
        int            done_cyc  = -1;
        int            hs_cyc    = -1;
        int            first_val = -1;
        int            busy_cnt  = 0;
        int            rdy_bad   = 0;
        bit            stalled   = 1'b0;
        logic [DAT_W+1:0] held   = '0;
        logic          go;
        beat_t         e;
        while (cyc < 300) begin
            if (stalled) begin
                check_output({tag, "_stall_hold"}, 64'({out_if.val, out_if.dat, out_if.sop, out_if.eop}),
                             64'({1'b1, held}));
            end
            if (out_if.val && first_val < 0) first_val = cyc;
            if (busy) busy_cnt++;
            if (busy && load_if.rdy) rdy_bad++;
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (done_cyc >= 0 && cyc == done_cyc + 1) begin
                check_output({tag, "_load_rdy_back"}, 64'(load_if.rdy), 64'(1));
            end
            if (poke && cyc == 4) begin
                start       = 1'b1;
                mode        = ~m;
                load_if.val = 1'b1;
                load_if.dat = pair(8'h55);
            end
            if (poke && cyc == 6) begin
                start       = 1'b0;
                mode        = 1'b0;
                load_if.val = 1'b0;
            end
            go = (rdy_pct >= 100) || ($urandom_range(0, 99) < rdy_pct);
            out_if.rdy = go;
            if (out_if.val && go) begin
                if (idx < exp_q.size()) begin
                    e = exp_q[idx];
                    check_output($sformatf("%s_beat%0d", tag, idx),
                                 64'({out_if.dat, out_if.sop, out_if.eop, out_if.ctl}),
                                 64'({pair(e.scl), e.sop, e.eop, 1'b0, m}));
                end else begin
                    check_output({tag, "_extra_beat"}, 64'(idx), 64'(exp_q.size()));
                end
                idx++;
                hs_cyc = cyc;
            end
            stalled = out_if.val && !go;
            held    = {out_if.dat, out_if.sop, out_if.eop};
            @(negedge clk);
            cyc++;
            if (done_cyc >= 0 && cyc > done_cyc + 3) break;
        end
        out_if.rdy = 1'b1;
        check_output({tag, "_beat_count"}, 64'(idx), 64'(exp_q.size()));
        check_output({tag, "_done_count"}, 64'(done_cnt), 64'(1));
        check_output({tag, "_done_after_last"}, 64'(done_cyc), 64'(hs_cyc + 1));
        check_output({tag, "_first_val_cycle"}, 64'(first_val), 64'(1));
        check_output({tag, "_load_rdy_while_busy"}, 64'(rdy_bad), 64'(0));
        if (exp_busy >= 0) begin
            check_output({tag, "_busy_cycles"}, 64'(busy_cnt), 64'(exp_busy));
        end
    endtask

    initial begin
        int n;
        int cyc;

        normal_tbl = '{
            '{8'd1, 1'b1, 1'b0}, '{8'd2, 1'b0, 1'b0}, '{8'd3, 1'b0, 1'b0}, '{8'd4, 1'b0, 1'b1},
            '{8'd1, 1'b1, 1'b0}, '{8'd2, 1'b0, 1'b0}, '{8'd3, 1'b0, 1'b0}, '{8'd4, 1'b0, 1'b1},
            '{8'd1, 1'b1, 1'b0}, '{8'd2, 1'b0, 1'b0}, '{8'd3, 1'b0, 1'b0}, '{8'd4, 1'b0, 1'b1}
        };

        load_if.val = 1'b0;
        load_if.sop = 1'b0;
        load_if.eop = 1'b0;
        load_if.dat = '0;
        load_if.ctl = '0;
        out_if.rdy  = 1'b1;

        // Reset values
        @(negedge clk);
        @(negedge clk);
        check_output("rst_val", 64'(out_if.val), 64'(0));
        check_output("rst_sop", 64'(out_if.sop), 64'(0));
        check_output("rst_eop", 64'(out_if.eop), 64'(0));
        check_output("rst_dat", 64'(out_if.dat), 64'(0));
        check_output("rst_ctl", 64'(out_if.ctl), 64'(0));
        check_output("rst_load_rdy", 64'(load_if.rdy), 64'(0));
        check_output("rst_busy", 64'(busy), 64'(0));
        check_output("rst_done", 64'(done), 64'(0));
        rst_n = 1'b1;

        for (int k = 1; k <= 4; k++) begin
            apply_stimulus(8'(k), k == 4);
        end

        // Normal run, full throughput, against the hand-written table
        exp_q.delete();
        for (int i = 0; i < 12; i++) exp_q.push_back(normal_tbl[i]);
        start_run(MODE_NORMAL);
        check_stream("normal", MODE_NORMAL, 100, 1'b0, 14);

        // Single-add: one beat of RAM[0]
        exp_q.delete();
        exp_q.push_back('{8'd1, 1'b1, 1'b1});
        start_run(MODE_SINGLE_ADD);
        check_stream("single", MODE_SINGLE_ADD, 100, 1'b0, 3);

        // Backpressure at roughly 30% ready duty
        exp_q.delete();
        for (int i = 0; i < 12; i++) exp_q.push_back(normal_tbl[i]);
        start_run(MODE_NORMAL);
        check_stream("bp", MODE_NORMAL, 30, 1'b0, -1);

        // Start and load attempts while streaming must be ignored
        start_run(MODE_NORMAL);
        check_stream("busy_poke", MODE_NORMAL, 100, 1'b1, 14);

        // Reset while beat 5 is on the stream
        start_run(MODE_NORMAL);
        out_if.rdy = 1'b1;
        n   = 0;
        cyc = 0;
        while (cyc < 40) begin
            if (out_if.val) begin
                if (n == 5) break;
                n++;
            end
            @(negedge clk);
            cyc++;
        end
        check_output("rst_mid_beat_index", 64'(n), 64'(5));
        check_output("rst_mid_beat5_dat", 64'(out_if.dat), 64'(pair(8'd2)));
        rst_n = 1'b0;
        @(negedge clk);
        check_output("rst_mid_val", 64'(out_if.val), 64'(0));
        check_output("rst_mid_done", 64'(done), 64'(0));
        check_output("rst_mid_busy", 64'(busy), 64'(0));
        @(negedge clk);
        check_output("rst_mid_done2", 64'(done), 64'(0));
        rst_n = 1'b1;

        start_run(MODE_NORMAL);
        check_stream("restart", MODE_NORMAL, 100, 1'b0, 14);

        // Write pointer wraps without eop: RAM becomes 5,6,3,4
        for (int k = 1; k <= 6; k++) begin
            apply_stimulus(8'(k), 1'b0);
        end
        build_normal({8'd4, 8'd3, 8'd6, 8'd5});
        start_run(MODE_NORMAL);
        check_stream("wrap", MODE_NORMAL, 100, 1'b0, -1);

        // eop forces the next write back to address 0: RAM becomes 7,6,9,4
        apply_stimulus(8'd9, 1'b1);
        apply_stimulus(8'd7, 1'b0);
        exp_q.delete();
        exp_q.push_back('{8'd7, 1'b1, 1'b1});
        start_run(MODE_SINGLE_ADD);
        check_stream("eop_single", MODE_SINGLE_ADD, 100, 1'b0, 3);
        build_normal({8'd4, 8'd9, 8'd6, 8'd7});
        start_run(MODE_NORMAL);
        check_stream("eop_normal", MODE_NORMAL, 100, 1'b0, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
